// File: rtl/axi_wr_slave.sv
// AXI write-channel responder: accepts one AW/W burst at a time, stores beats in a word-addressed
// memory and answers each burst with a single B response (SLVERR when wlast disagrees with awlen).
module axi_wr_slave #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_AW       = 8,
  parameter int WREADY_STALL = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic [MEM_AW-1:0]     rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           burst_cnt,
  output logic                  err
);

  localparam int MEM_DEPTH = 2 ** MEM_AW;
  localparam logic [15:0] STALL_LAST = (WREADY_STALL > 0) ? 16'(WREADY_STALL - 1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_DATA = 2'd1,
    B_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [7:0]              len_r;
  logic [7:0]              beat_r;
  logic                    lasterr_r;
  logic [15:0]             stall_cnt_r;
  logic                    wready_r;
  logic                    bvalid_r;
  logic [1:0]              bresp_r;
  logic [15:0]             burst_cnt_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic aw_fire_s;
  logic w_fire_s;
  logic b_fire_s;
  logic len_done_s;
  logic end_beat_s;
  logic mismatch_s;
  logic stall_now_s;

  function automatic logic [1:0] resp_code(input logic slverr);
    resp_code = slverr ? 2'b10 : 2'b00;
  endfunction

  assign awready     = (state_r == IDLE);
  assign wready      = wready_r;
  assign bvalid      = bvalid_r;
  assign bresp       = bresp_r;
  assign burst_cnt   = burst_cnt_r;
  assign err         = err_r;
  assign rd_data     = mem[rd_idx];

  assign aw_fire_s   = awvalid && (state_r == IDLE);
  assign w_fire_s    = wvalid && wready_r && (state_r == W_DATA);
  assign b_fire_s    = bvalid_r && bready && (state_r == B_RESP);
  assign len_done_s  = (beat_r == len_r);
  assign end_beat_s  = len_done_s || wlast;
  assign mismatch_s  = (wlast != len_done_s);
  assign stall_now_s = (WREADY_STALL > 0) && (stall_cnt_r == STALL_LAST);

  // Burst FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      len_r       <= 8'd0;
      beat_r      <= 8'd0;
      lasterr_r   <= 1'b0;
      stall_cnt_r <= 16'd0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      burst_cnt_r <= 16'd0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wready_r <= 1'b0;
          bvalid_r <= 1'b0;
          if (aw_fire_s) begin
            addr_r      <= awaddr;
            len_r       <= awlen;
            beat_r      <= 8'd0;
            lasterr_r   <= 1'b0;
            stall_cnt_r <= 16'd0;
            state_r     <= W_DATA;
          end else begin
            state_r <= IDLE;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            addr_r <= addr_r + ADDR_WIDTH'(1);
            beat_r <= beat_r + 8'd1;
            if (end_beat_s) begin
              // Response is decided on the closing beat so B_RESP can present it immediately.
              lasterr_r <= lasterr_r | mismatch_s;
              bresp_r   <= resp_code(lasterr_r | mismatch_s);
              bvalid_r  <= 1'b1;
              wready_r  <= 1'b0;
              state_r   <= B_RESP;
            end else if (stall_now_s) begin
              wready_r    <= 1'b0;
              stall_cnt_r <= 16'd0;
            end else begin
              stall_cnt_r <= stall_cnt_r + 16'd1;
            end
          end else if (!wready_r) begin
            wready_r <= 1'b1;
          end else begin
            wready_r <= wready_r;
          end
        end
        B_RESP: begin
          wready_r <= 1'b0;
          if (b_fire_s) begin
            bvalid_r    <= 1'b0;
            bresp_r     <= 2'b00;
            burst_cnt_r <= burst_cnt_r + 16'd1;
            err_r       <= err_r | lasterr_r;
            state_r     <= IDLE;
          end else begin
            state_r <= B_RESP;
          end
        end
        default: begin
          state_r  <= IDLE;
          wready_r <= 1'b0;
          bvalid_r <= 1'b0;
          bresp_r  <= 2'b00;
        end
      endcase
    end
  end

  // Backing store: deliberately not reset so words survive a reset mid-burst.
  always_ff @(posedge clk) begin
    if (w_fire_s) begin
      mem[addr_r[MEM_AW-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Bench for axi_wr_slave: table of single bursts, hand sequences for stall/back-pressure/reset,
// then randomized well-formed traffic checked against a plain array memory model.
module tb_axi_wr_slave;
  localparam int AW = 16, DW = 32, MAW = 8, STALL = 2, DEPTH = 256;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [AW-1:0]  awaddr = '0;
  logic [7:0]     awlen = 8'd0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic           wlast = 1'b0;
  logic [DW-1:0]  wdata = '0;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [1:0]     bresp;
  logic [MAW-1:0] rd_idx = '0;
  logic [DW-1:0]  rd_data;
  logic [15:0]    burst_cnt;
  logic           err;

  always #5 clk = ~clk;

  axi_wr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .WREADY_STALL(STALL)) dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .rd_idx(rd_idx), .rd_data(rd_data), .burst_cnt(burst_cnt), .err(err)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_mem [DEPTH];
  bit            written [DEPTH];
  int            exp_cnt = 0;
  bit            exp_err = 1'b0;

  typedef struct {
    logic [15:0] addr;
    int          len;
    int          wlast_at;   // beat index carrying wlast; beyond len means never asserted
    int          delay;      // cycles bready held low once bvalid is up
    logic [7:0]  base;
    logic [1:0]  exp_bresp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int beats_of(input int len, input int wlast_at);
    return (wlast_at < len) ? wlast_at + 1 : len + 1;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [DW-1:0] d);
    int idx;
    idx = int'(a) % DEPTH;
    exp_mem[idx] = d;
    written[idx] = 1'b1;
  endtask

  task automatic do_aw(input logic [15:0] a, input logic [7:0] l);
    int t;
    t = 0;
    awaddr = a; awlen = l; awvalid = 1'b1;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_timeout", 64'(t < 50), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] a, input int wlast_at, input logic [7:0] base,
                            input bit rnd, input int nsend);
    int t;
    logic [DW-1:0] d;
    for (int i = 0; i < nsend; i++) begin
      if (rnd && ($urandom_range(0, 3) == 0)) begin
        wvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      d = rnd ? DW'($urandom) : {16'hD000, base, 8'(i)};
      wvalid = 1'b1; wdata = d; wlast = (i == wlast_at);
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      chk("w_timeout", 64'(t < 50), 64'd1);
      model_write(a + 16'(i), d);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase(input int delay, input logic [1:0] eb);
    int t;
    t = 0;
    bready = (delay == 0);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    chk("b_timeout", 64'(t < 50), 64'd1);
    for (int d = 0; d < delay; d++) begin
      chk("bvalid_hold", 64'(bvalid), 64'd1);
      chk("bresp_hold", 64'(bresp), 64'(eb));
      chk("awready_in_b", 64'(awready), 64'd0);
      awvalid = 1'b1; awaddr = 16'h0BAD; awlen = 8'd0;
      @(negedge clk);
    end
    awvalid = 1'b0; bready = 1'b1;
    chk("bresp", 64'(bresp), 64'(eb));
    @(negedge clk);
    bready = 1'b0;
    exp_cnt++;
    if (eb == 2'b10) exp_err = 1'b1;
    chk("bvalid_after_b", 64'(bvalid), 64'd0);
    chk("awready_after_b", 64'(awready), 64'd1);
    chk("burst_cnt", 64'(burst_cnt), 64'(exp_cnt % 65536));
    chk("err", 64'(err), 64'(exp_err));
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) begin
      if (written[i]) begin
        rd_idx = MAW'(i);
        #1;
        chk($sformatf("mem[%0d]", i), 64'(rd_data), 64'(exp_mem[i]));
      end
    end
    @(negedge clk);
  endtask

  task automatic run_burst(input vec_t v, input bit rnd);
    do_aw(v.addr, 8'(v.len));
    send_beats(v.addr, v.wlast_at, v.base, rnd, beats_of(v.len, v.wlast_at));
    b_phase(v.delay, v.exp_bresp);
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v;
    logic exp_wr [$];
    int beat, t;

    tbl[0] = '{addr: 16'h0010, len: 7, wlast_at: 7,  delay: 0, base: 8'h00, exp_bresp: 2'b00};
    tbl[1] = '{addr: 16'h0020, len: 7, wlast_at: 3,  delay: 1, base: 8'h01, exp_bresp: 2'b10};
    tbl[2] = '{addr: 16'h0030, len: 3, wlast_at: 3,  delay: 0, base: 8'h02, exp_bresp: 2'b00};
    tbl[3] = '{addr: 16'h00FE, len: 3, wlast_at: 3,  delay: 2, base: 8'hA0, exp_bresp: 2'b00};
    tbl[4] = '{addr: 16'h0050, len: 0, wlast_at: 0,  delay: 0, base: 8'h04, exp_bresp: 2'b00};
    tbl[5] = '{addr: 16'h0060, len: 0, wlast_at: 99, delay: 0, base: 8'h05, exp_bresp: 2'b10};
    tbl[6] = '{addr: 16'hFFFE, len: 3, wlast_at: 3,  delay: 0, base: 8'h06, exp_bresp: 2'b00};
    tbl[7] = '{addr: 16'h0070, len: 5, wlast_at: 99, delay: 5, base: 8'h07, exp_bresp: 2'b10};

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    for (int r = 0; r < 8; r++) begin
      run_burst(tbl[r], 1'b0);
      check_mem();
    end

    // Beat-exact wready trace with wvalid held high: low on entry, then after every 2nd beat.
    do_aw(16'h0080, 8'd7);
    exp_wr.push_back(1'b0);
    for (int b = 1; b <= 8; b++) begin
      exp_wr.push_back(1'b1);
      if ((b % STALL) == 0 && b < 8) exp_wr.push_back(1'b0);
    end
    exp_wr.push_back(1'b0);
    beat = 0;
    foreach (exp_wr[k]) begin
      wvalid = (beat < 8); wdata = 32'hC000_0000 + DW'(beat); wlast = (beat == 7);
      chk($sformatf("wready_trace[%0d]", k), 64'(wready), 64'(exp_wr[k]));
      if (wready && beat < 8) begin
        model_write(16'h0080 + 16'(beat), wdata);
        beat++;
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_phase(0, 2'b00);
    check_mem();

    // Reset in the middle of a burst: three words land, no response is ever issued.
    do_aw(16'h0040, 8'd7);
    send_beats(16'h0040, 7, 8'h40, 1'b0, 3);
    rstn = 1'b0;
    #1;
    chk("midrst_awready", 64'(awready), 64'd1);
    chk("midrst_wready", 64'(wready), 64'd0);
    chk("midrst_bvalid", 64'(bvalid), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0; exp_err = 1'b0;
    @(negedge clk);
    chk("postrst_burst_cnt", 64'(burst_cnt), 64'd0);
    chk("postrst_err", 64'(err), 64'd0);
    chk("postrst_bvalid", 64'(bvalid), 64'd0);
    v = '{addr: 16'h0090, len: 7, wlast_at: 7, delay: 0, base: 8'h09, exp_bresp: 2'b00};
    run_burst(v, 1'b0);
    check_mem();

    for (int n = 0; n < 100; n++) begin
      v.addr = 16'($urandom);
      v.len = $urandom_range(0, 15);
      v.wlast_at = v.len;
      v.delay = $urandom_range(0, 3);
      v.base = 8'(n);
      v.exp_bresp = 2'b00;
      run_burst(v, 1'b1);
    end
    chk("final_burst_cnt", 64'(burst_cnt), 64'd101);
    chk("final_err", 64'(err), 64'd0);
    check_mem();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
